// File: rtl/bat_program_loader_pkg.sv
// Shared state encoding and stream byte-order helpers for the program loader.
// Pure definitions: no latency, no flow control.
package bat_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_RESET_CPU,
        ST_DONE
    } state_t;

    // Stream is big-endian: the first byte of each pair is the high byte.
    localparam bit HI_BYTE_FIRST = 1'b1;

    function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
        return HI_BYTE_FIRST ? {first, second} : {second, first};
    endfunction

    function automatic logic rx_state(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

    function automatic logic halt_state(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/bat_loader_ctr.sv
// Loadable down-counter with zero/one flags; load wins over decrement, saturates at 0.
// Flags are combinational from the count register; no flow control.
module bat_loader_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         is_zero,
    output logic         is_one
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !is_zero) begin
            count <= count - W'(1);
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == W'(1));

endmodule

// File: rtl/bat_program_loader.sv
// Loads a length-prefixed word stream into core RAM under HALT, then pulses CPU_RST.
// Outputs registered; one word per 3 cycles best case; BYTE_READY drops during WRITE/RESET_CPU.
module bat_program_loader
    import bat_program_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int          RESET_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic [15:0] ADDRESS,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    output logic        RW,
    output logic        RAM_EN,
    output logic        HALT,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  len_hi;
    logic [7:0]  word_hi;
    logic [15:0] addr_ptr;
    logic [15:0] len_word;
    logic        accept;
    logic        rem_load, rem_dec, rem_zero, rem_one;
    logic        rst_load, rst_dec, rst_zero, rst_one;

    assign accept   = BYTE_VALID && BYTE_READY;
    assign len_word = pack_word(len_hi, BYTE_IN);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (START) next_state = ST_LEN_HI;
            ST_LEN_HI:        if (accept) next_state = ST_LEN_LO;
            ST_LEN_LO:        if (accept) next_state = (len_word == 16'd0) ? ST_RESET_CPU : ST_DATA_HI;
            ST_DATA_HI:       if (accept) next_state = ST_DATA_LO;
            ST_DATA_LO:       if (accept) next_state = ST_WRITE;
            ST_WRITE:         next_state = (rem_one || rem_zero) ? ST_RESET_CPU : ST_DATA_HI;
            ST_RESET_CPU:     if (rst_one || rst_zero) next_state = ST_DONE;
            default:          next_state = ST_IDLE;
        endcase
    end

    assign rem_load = (state == ST_LEN_LO) && accept;
    assign rem_dec  = (state == ST_WRITE);
    // The pulse counter is armed on the transition into RESET_CPU so it spans exactly RESET_CYCLES.
    assign rst_load = (next_state == ST_RESET_CPU) && (state != ST_RESET_CPU);
    assign rst_dec  = (state == ST_RESET_CPU);

    bat_loader_ctr #(.W(16)) u_rem_ctr (
        .clk      (CLK),
        .rst      (RST),
        .load     (rem_load),
        .dec      (rem_dec),
        .load_val (len_word),
        .is_zero  (rem_zero),
        .is_one   (rem_one)
    );

    bat_loader_ctr #(.W(16)) u_rst_ctr (
        .clk      (CLK),
        .rst      (RST),
        .load     (rst_load),
        .dec      (rst_dec),
        .load_val (16'(RESET_CYCLES)),
        .is_zero  (rst_zero),
        .is_one   (rst_one)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            len_hi     <= '0;
            word_hi    <= '0;
            addr_ptr   <= '0;
            BYTE_READY <= 1'b0;
            ADDRESS    <= '0;
            DATA_OUT   <= '0;
            DATA_OE    <= 1'b0;
            RW         <= 1'b0;
            RAM_EN     <= 1'b0;
            HALT       <= 1'b0;
            CPU_RST    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= next_state;
            BYTE_READY <= rx_state(next_state);
            HALT       <= halt_state(next_state);
            BUSY       <= halt_state(next_state);
            CPU_RST    <= (next_state == ST_RESET_CPU);
            DONE       <= (next_state == ST_DONE);
            // Bus outputs are ORed into the core's own drivers, so they must idle at 0.
            ADDRESS    <= '0;
            DATA_OUT   <= '0;
            DATA_OE    <= 1'b0;
            RW         <= 1'b0;
            RAM_EN     <= 1'b0;
            if ((state == ST_IDLE || state == ST_DONE) && START) begin
                addr_ptr <= BASE_ADDR;
            end
            if (accept && state == ST_LEN_HI) begin
                len_hi <= BYTE_IN;
            end
            if (accept && state == ST_DATA_HI) begin
                word_hi <= BYTE_IN;
            end
            if (accept && state == ST_DATA_LO) begin
                ADDRESS  <= addr_ptr;
                DATA_OUT <= pack_word(word_hi, BYTE_IN);
                DATA_OE  <= 1'b1;
                RW       <= 1'b1;
                RAM_EN   <= 1'b1;
            end
            if (state == ST_WRITE) begin
                addr_ptr <= addr_ptr + 16'd1;
            end
        end
    end

endmodule
